// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider: quotient on Z_High, remainder on Z_Low.
// Divides operand magnitudes, then restores signs (quotient toward zero, remainder follows dividend).
module seq_divider #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Z_High,
  output logic [WIDTH-1:0] Z_Low,
  output logic             ready,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] divisor, rem, quo;
  logic [CW-1:0]    count;
  logic             qneg, rneg;
  logic [WIDTH:0]   shifted, trial;
  logic             fits, accept, b_zero;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (SIGNED && v[WIDTH-1]) return -v;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // Remainder is always below the divisor, so a WIDTH+1 trial never overflows its sign bit
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    fits    = ~trial[WIDTH];
    b_zero  = (B == '0);
    accept  = start && ((state == IDLE) || (state == DONE));
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: if (start) state_next = b_zero ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (count == CW'(WIDTH - 1)) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        ready = 1'b1;
        if (start) state_next = b_zero ? DONE : RUN;
        else       state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      Z_High      <= '0;
      Z_Low       <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        count <= '0;
        if (b_zero) begin
          Z_High      <= '1;
          Z_Low       <= A;
          div_by_zero <= 1'b1;
        end else begin
          div_by_zero <= 1'b0;
        end
      end else if (state == RUN) begin
        count <= count + 1'b1;
      end
      if (state == FIX) begin
        Z_High <= apply_sign(quo, qneg);
        Z_Low  <= apply_sign(rem, rneg);
      end
    end
  end

  // Working registers are fully reloaded on every accepted start, so they need no reset
  always_ff @(posedge clk) begin
    if (accept && !b_zero) begin
      divisor <= magnitude(B);
      quo     <= magnitude(A);
      rem     <= '0;
      qneg    <= SIGNED ? (A[WIDTH-1] ^ B[WIDTH-1]) : 1'b0;
      rneg    <= SIGNED ? A[WIDTH-1] : 1'b0;
    end else if (state == RUN) begin
      rem <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], fits};
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=32, SIGNED=1): directed vectors plus random signed cases.
module tb_seq_divider;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] Z_High, Z_Low;
  logic         ready, busy, div_by_zero;

  seq_divider #(.WIDTH(W), .SIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .Z_High(Z_High), .Z_Low(Z_Low), .ready(ready), .busy(busy),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         dbz;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h required 0x%h", name, act, exp);
    end
  endtask

  // Monitor: every ready pulse pops one expected result
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && ready === 1'b1) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_ready: got ready=1 required no pending result");
      end else begin
        e = sbq.pop_front();
        chk("quotient", Z_High, e.q);
        chk("remainder", Z_Low, e.r);
        chk("div_by_zero", W'(div_by_zero), W'(e.dbz));
        if (!e.dbz) chk("invariant", Z_High * e.b + Z_Low, e.a);
      end
    end
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                        input logic [W-1:0] r, input logic dbz, input bit push);
    A     = a;
    B     = b;
    start = 1'b1;
    if (push) sbq.push_back('{a, b, q, r, dbz});
  endtask

  task automatic wait_done(input string name, input int exp_lat, input logic exp_busy1,
                           input logic exp_dbz1, input int glitch_at);
    int cycles = 0;
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      cycles++;
      if (cycles == glitch_at) begin
        A     = 32'd9;
        B     = 32'd3;
        start = 1'b1;
      end
      if (cycles == 1) begin
        chk({name, "_busy"}, W'(busy), W'(exp_busy1));
        chk({name, "_dbz_after_accept"}, W'(div_by_zero), W'(exp_dbz1));
      end
      if (ready === 1'b1) seen = 1;
    end
    chk({name, "_latency"}, W'(cycles), W'(exp_lat));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic signed [W-1:0] sa, sb;
    logic [W-1:0] q, r;

    #3;
    chk("reset_zhigh", Z_High, '0);
    chk("reset_zlow", Z_Low, '0);
    chk("reset_flags", W'({ready, busy, div_by_zero}), '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    @(negedge clk);
    launch(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1);
    wait_done("t1", 34, 1'b1, 1'b0, 0);

    @(negedge clk);
    launch(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 1);
    wait_done("t2a", 34, 1'b1, 1'b0, 0);
    @(negedge clk);
    launch(32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 1'b0, 1);
    wait_done("t2b", 34, 1'b1, 1'b0, 0);

    @(negedge clk);
    launch(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1);
    wait_done("t3", 1, 1'b0, 1'b1, 0);
    @(negedge clk);
    launch(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 1);
    wait_done("t3_clear", 34, 1'b1, 1'b0, 0);

    @(negedge clk);
    launch(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 1);
    wait_done("t4", 34, 1'b1, 1'b0, 0);

    @(negedge clk);
    launch(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1);
    wait_done("t5_ignore", 34, 1'b1, 1'b0, 10);
    launch(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1);
    wait_done("t5_b2b", 34, 1'b1, 1'b0, 0);

    @(negedge clk);
    launch(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_zhigh", Z_High, '0);
    chk("midreset_zlow", Z_Low, '0);
    chk("midreset_flags", W'({ready, busy, div_by_zero}), '0);
    @(negedge clk);
    chk("reset_hold_flags", W'({ready, busy}), '0);
    rst_n = 1'b1;
    @(negedge clk);
    launch(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1);
    wait_done("t6", 34, 1'b1, 1'b0, 0);

    for (int n = 0; n < 8; n++) begin
      sa = $signed($urandom);
      sb = $signed($urandom >> $urandom_range(0, 28));
      if ($urandom_range(0, 1) == 1) sb = -sb;
      if (sb == 0) sb = 1;
      if (sa == 32'sh80000000 && sb == -1) sb = 3;
      q = sa / sb;
      r = sa % sb;
      @(negedge clk);
      launch(sa, sb, q, r, 1'b0, 1);
      wait_done("rand", 34, 1'b1, 1'b0, 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", W'(sbq.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
